// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexes four 4-bit digit codes onto one
// seven-segment decoder input, with entry-length blanking and a timed
// "Err" override after a failed unlock.
// Optional build macro: BLINK_EN -- blinks the "Err" message, toggling
// every BLINK_DIV scan frames. Without it "Err" is shown steadily.
module display_scan_mux #(
    parameter int SCAN_DIV  = 1000,
    parameter int ERR_HOLD  = 50000000,
    parameter int BLINK_DIV = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic [2:0]  entry_count,
    input  logic        show_err,
    output logic [3:0]  code_out,
    output logic [3:0]  an_out,
    output logic        err_active
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int TW = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(ERR_HOLD - 1);

    typedef enum logic {NORM, ERR} state_t;

    state_t        r_state;
    logic [PW-1:0] r_pre;
    logic [1:0]    r_idx;
    logic [TW-1:0] r_tmr;

    logic          w_wrap;
    logic          w_frame_end;
    logic          w_off;
    logic [2:0]    w_eff;
    logic [3:0]    w_norm_code;
    logic [3:0]    w_err_code;

    assign w_wrap      = (r_pre == PRE_LAST);
    assign w_frame_end = w_wrap && (r_idx == 2'd3);

    // Prescaler and digit index; only reset clears them, never the FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= 2'd0;
        end else if (w_wrap) begin
            r_pre <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Digit code selection for the currently scanned position
    always_comb begin
        w_eff       = (entry_count > 3'd4) ? 3'd4 : entry_count;
        w_norm_code = ({1'b0, r_idx} < w_eff) ? digits_in[{r_idx, 2'b00} +: 4] : 4'hF;
        case (r_idx)
            2'd3:    w_err_code = 4'hC;
            2'd2:    w_err_code = 4'hD;
            2'd1:    w_err_code = 4'hD;
            default: w_err_code = 4'hF;
        endcase
    end

`ifdef BLINK_EN
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_DIV - 1);

    logic [FW-1:0] r_frm;
    logic          r_blink_off;

    // Blink phase only matters in ERR; leftover phase in NORM is ignored
    assign w_off = r_blink_off && (r_state == ERR);
`else
    assign w_off = 1'b0;
`endif

    // Err state machine: entry, hold timer with retrigger priority, exit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= NORM;
            r_tmr      <= '0;
            err_active <= 1'b0;
`ifdef BLINK_EN
            r_frm       <= '0;
            r_blink_off <= 1'b0;
`endif
        end else begin
            case (r_state)
                NORM: begin
                    if (show_err) begin
                        r_state    <= ERR;
                        r_tmr      <= TMR_LOAD;
                        err_active <= 1'b1;
`ifdef BLINK_EN
                        r_frm       <= '0;
                        r_blink_off <= 1'b0;
`endif
                    end
                end
                ERR: begin
                    if (show_err) begin
                        r_tmr <= TMR_LOAD;
                    end else if (r_tmr == '0) begin
                        r_state    <= NORM;
                        err_active <= 1'b0;
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
`ifdef BLINK_EN
                    if (w_frame_end) begin
                        if (r_frm == FRM_LAST) begin
                            r_frm       <= '0;
                            r_blink_off <= ~r_blink_off;
                        end else begin
                            r_frm <= r_frm + 1'b1;
                        end
                    end
`endif
                end
                default: r_state <= NORM;
            endcase
        end
    end

    // Registered outputs; one all-off guard cycle at each digit change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_out <= 4'hF;
            an_out   <= 4'b1111;
        end else begin
            if (w_wrap || w_off)
                an_out <= 4'b1111;
            else
                an_out <= ~(4'b0001 << r_idx);
            if (w_off)
                code_out <= 4'hF;
            else if (r_state == ERR)
                code_out <= w_err_code;
            else
                code_out <= w_norm_code;
        end
    end

    // Frame boundary is only consumed by the blink logic
    logic w_unused;
    assign w_unused = w_frame_end;

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: directed test-plan sequences followed by
// random stimulus, compared each cycle against a cycle-count model.
module tb_display_scan_mux;

    localparam int SD = 4;
    localparam int EH = 20;
    localparam int BD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits_in;
    logic [2:0]  entry_count;
    logic        show_err;
    logic [3:0]  code_out;
    logic [3:0]  an_out;
    logic        err_active;

    display_scan_mux #(.SCAN_DIV(SD), .ERR_HOLD(EH), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .entry_count(entry_count),
        .show_err(show_err), .code_out(code_out), .an_out(an_out),
        .err_active(err_active)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // model state: edges since reset release, err flag, hold timer, frames in ERR
    int k;
    bit m_err;
    int m_tmr;
    int m_frames;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        k = 0; m_err = 0; m_tmr = 0; m_frames = 0;
    endtask

    // one clock: predict outputs from pre-edge model state, advance model, compare
    task automatic step();
        int pre, idx, ec;
        bit off;
        logic [3:0] e_code, e_an;
        pre = k % SD;
        idx = (k / SD) % 4;
        off = 0;
`ifdef BLINK_EN
        off = m_err && (((m_frames / BD) % 2) == 1);
`endif
        ec = (entry_count > 3'd4) ? 4 : int'(entry_count);
        if (off)        e_code = 4'hF;
        else if (m_err) e_code = (idx == 3) ? 4'hC : (idx == 0) ? 4'hF : 4'hD;
        else            e_code = (idx < ec) ? digits_in[4*idx +: 4] : 4'hF;
        e_an = 4'b1111;
        if (!(pre == SD - 1 || off)) e_an[idx] = 1'b0;
        @(posedge clk);
        if (m_err) begin
            if (pre == SD - 1 && idx == 3) m_frames++;
            if (show_err)        m_tmr = EH - 1;
            else if (m_tmr == 0) m_err = 0;
            else                 m_tmr--;
        end else if (show_err) begin
            m_err = 1; m_tmr = EH - 1; m_frames = 0;
        end
        k++;
        #1;
        chk("an_out", 32'(an_out), 32'(e_an));
        chk("code_out", 32'(code_out), 32'(e_code));
        chk("err_active", 32'(err_active), 32'(m_err));
    endtask

    task automatic pulse_err();
        show_err = 1'b1;
        step();
        show_err = 1'b0;
    endtask

    // asynchronous reset away from any edge, then release at a falling edge
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_code", 32'(code_out), 32'h0000000F);
        chk("rst_an", 32'(an_out), 32'h0000000F);
        chk("rst_err", 32'(err_active), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_hold_an", 32'(an_out), 32'h0000000F);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        digits_in = 16'h1234;
        entry_count = 3'd4;
        show_err = 1'b0;
        #3;
        chk("init_code", 32'(code_out), 32'h0000000F);
        chk("init_an", 32'(an_out), 32'h0000000F);
        chk("init_err", 32'(err_active), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // scan order and full display
        repeat (20) step();
        // mid-cycle async reset while showing digits
        do_reset();
        repeat (16) step();
        entry_count = 3'd2;
        repeat (16) step();
        entry_count = 3'd7;
        repeat (16) step();

        // Err entry, retrigger at 15 cycles, pulse coincident with expiry
        pulse_err();
        repeat (14) step();
        pulse_err();
        repeat (19) step();
        pulse_err();
        repeat (30) step();

        // long ERR kept alive by retriggers, spans several frames
        repeat (8) begin
            pulse_err();
            repeat (15) step();
        end
        repeat (25) step();

        // reset during ERR, then back to normal digits
        pulse_err();
        repeat (5) step();
        do_reset();
        digits_in = 16'h9A5B;
        entry_count = 3'd3;
        repeat (20) step();

        // random digits, counts and occasional triggers
        repeat (600) begin
            digits_in = 16'($urandom);
            entry_count = 3'($urandom_range(0, 7));
            show_err = ($urandom_range(0, 29) == 0);
            step();
        end
        show_err = 1'b0;
        repeat (30) step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
